// File: rtl/game_flow_ctrl_pkg.sv
// Shared types for the match sequencer: game states, winner codes, BCD digits.
// The PAUSED state exists only when GAME_PAUSE_EN is defined.
package game_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PLAY     = 3'd1,
    DYING    = 3'd2,
    GAMEOVER = 3'd3,
`ifdef GAME_PAUSE_EN
    DRAW     = 3'd4,
    PAUSED   = 3'd5
`else
    DRAW     = 3'd4
`endif
  } game_state_t;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;

  typedef logic [3:0] bcd_t;

  typedef struct packed {
    bcd_t hund;
    bcd_t ten;
    bcd_t one;
  } bcd3_t;

  // Binary 0..999 to three BCD digits (elaboration-time use).
  function automatic bcd3_t to_bcd3(input int unsigned v);
    bcd3_t r;
    r.hund = bcd_t'((v / 100) % 10);
    r.ten  = bcd_t'((v / 10) % 10);
    r.one  = bcd_t'(v % 10);
    return r;
  endfunction

endpackage

// File: rtl/game_flow_ctrl_if.sv
// Bundle between the match sequencer and its consumers (color_mapper,
// tank/bullet motion). slave = sequencer side, master = environment side.
// Inputs : start, tank1_alive, tank2_alive, pause (GAME_PAUSE_EN only)
// Outputs: state, play_en, hund_sec/ten_sec/one_sec, dying_tank,
//          death_frame, winner, game_over, draw
interface game_flow_ctrl_if;
  logic       start;
  logic       tank1_alive;
  logic       tank2_alive;
`ifdef GAME_PAUSE_EN
  logic       pause;
`endif
  logic [2:0] state;
  logic       play_en;
  logic [3:0] hund_sec;
  logic [3:0] ten_sec;
  logic [3:0] one_sec;
  logic [1:0] dying_tank;
  logic [2:0] death_frame;
  logic [1:0] winner;
  logic       game_over;
  logic       draw;

`ifdef GAME_PAUSE_EN
  modport slave (
    input  start, tank1_alive, tank2_alive, pause,
    output state, play_en, hund_sec, ten_sec, one_sec,
           dying_tank, death_frame, winner, game_over, draw
  );
  modport master (
    output start, tank1_alive, tank2_alive, pause,
    input  state, play_en, hund_sec, ten_sec, one_sec,
           dying_tank, death_frame, winner, game_over, draw
  );
`else
  modport slave (
    input  start, tank1_alive, tank2_alive,
    output state, play_en, hund_sec, ten_sec, one_sec,
           dying_tank, death_frame, winner, game_over, draw
  );
  modport master (
    output start, tank1_alive, tank2_alive,
    input  state, play_en, hund_sec, ten_sec, one_sec,
           dying_tank, death_frame, winner, game_over, draw
  );
`endif
endinterface

// File: rtl/game_flow_ctrl_bcd_counter3.sv
// Three-digit BCD up counter (000..999, wraps to 000).
// Ports: frame_clk, Reset (async, active-high), i_clr (highest priority),
//        i_hold (freezes value), i_inc (advance by one), o_value (digits).
module bcd_counter3
  import game_pkg::*;
(
  input  logic  frame_clk,
  input  logic  Reset,
  input  logic  i_inc,
  input  logic  i_clr,
  input  logic  i_hold,
  output bcd3_t o_value
);

  bcd3_t r_val;

  // Ripple carry ones -> tens -> hundreds.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      r_val <= '0;
    end else if (i_clr) begin
      r_val <= '0;
    end else if (!i_hold && i_inc) begin
      if (r_val.one != 4'd9) begin
        r_val.one <= r_val.one + 4'd1;
      end else begin
        r_val.one <= 4'd0;
        if (r_val.ten != 4'd9) begin
          r_val.ten <= r_val.ten + 4'd1;
        end else begin
          r_val.ten  <= 4'd0;
          r_val.hund <= (r_val.hund == 4'd9) ? 4'd0 : r_val.hund + 4'd1;
        end
      end
    end
  end

  assign o_value = r_val;

endmodule

// File: rtl/game_flow_ctrl.sv
// Match sequencer for the two-player tank game, clocked once per frame.
// Runs the BCD round timer, watches the alive flags and walks
// IDLE -> PLAY -> DYING -> GAMEOVER/DRAW. Optional macro GAME_PAUSE_EN adds
// the pause input and the PAUSED state.
// Ports: frame_clk, Reset (async, active-high), bus (game_flow_ctrl_if.slave).
module game_flow_ctrl
  import game_pkg::*;
#(
  parameter int unsigned FRAMES_PER_SEC = 60,
  parameter int unsigned DEATH_FRAMES   = 25,
  parameter int unsigned DEATH_STEP     = 5,
  parameter int unsigned TIME_LIMIT     = 250
)
(
  input logic              frame_clk,
  input logic              Reset,
  game_flow_ctrl_if.slave  bus
);

  localparam int unsigned CNT_W = 8;
  // Limit is detected one count early so the exit coincides with the tick.
  localparam bcd3_t LIMIT_M1 = to_bcd3(TIME_LIMIT - 1);

  game_state_t      r_state, w_state_nxt;
  logic             r_start_q;
  logic [CNT_W-1:0] r_frame_cnt, w_frame_cnt_nxt;
  logic [CNT_W-1:0] r_death_cnt, w_death_cnt_nxt;
  logic [1:0]       r_dying_tank, w_dying_nxt;
  logic [1:0]       r_winner, w_winner_nxt;
  logic [2:0]       r_death_frame, w_death_frame_nxt;
  logic             r_play_en, r_game_over, r_draw;
  logic             w_cnt_inc, w_cnt_clr, w_cnt_hold;
  logic             w_start_rise, w_sec_tick, w_limit_tick, w_any_dead;
  int unsigned      w_death_div;
  bcd3_t            w_digits;

  assign w_start_rise = bus.start & ~r_start_q;
  assign w_sec_tick   = (r_frame_cnt == CNT_W'(FRAMES_PER_SEC - 1));
  assign w_limit_tick = w_sec_tick && (w_digits == LIMIT_M1);
  assign w_any_dead   = ~bus.tank1_alive | ~bus.tank2_alive;

`ifdef GAME_PAUSE_EN
  logic r_pause_q;
  logic w_pause_rise;
  assign w_pause_rise = bus.pause & ~r_pause_q;
`endif

  bcd_counter3 u_timer (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .i_inc     (w_cnt_inc),
    .i_clr     (w_cnt_clr),
    .i_hold    (w_cnt_hold),
    .o_value   (w_digits)
  );

  // State and datapath registers.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      r_state       <= IDLE;
      r_start_q     <= 1'b0;
      r_frame_cnt   <= '0;
      r_death_cnt   <= '0;
      r_dying_tank  <= 2'b00;
      r_winner      <= WIN_NONE;
      r_death_frame <= 3'd0;
      r_play_en     <= 1'b0;
      r_game_over   <= 1'b0;
      r_draw        <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_start_q     <= bus.start;
      r_frame_cnt   <= w_frame_cnt_nxt;
      r_death_cnt   <= w_death_cnt_nxt;
      r_dying_tank  <= w_dying_nxt;
      r_winner      <= w_winner_nxt;
      r_death_frame <= w_death_frame_nxt;
      // Flags registered from next state equal a decode of the state register.
      r_play_en     <= (w_state_nxt == PLAY);
      r_game_over   <= (w_state_nxt == GAMEOVER);
      r_draw        <= (w_state_nxt == DRAW);
    end
  end

`ifdef GAME_PAUSE_EN
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) r_pause_q <= 1'b0;
    else       r_pause_q <= bus.pause;
  end
`endif

  // Next-state and datapath control.
  always_comb begin
    w_state_nxt     = r_state;
    w_frame_cnt_nxt = r_frame_cnt;
    w_death_cnt_nxt = r_death_cnt;
    w_dying_nxt     = r_dying_tank;
    w_winner_nxt    = r_winner;
    w_cnt_inc       = 1'b0;
    w_cnt_clr       = 1'b0;
    w_cnt_hold      = 1'b1;

    case (r_state)
      IDLE: begin
        w_cnt_clr       = 1'b1;
        w_frame_cnt_nxt = '0;
        w_death_cnt_nxt = '0;
        w_dying_nxt     = 2'b00;
        w_winner_nxt    = WIN_NONE;
        if (w_start_rise) w_state_nxt = PLAY;
      end

      PLAY: begin
        // Timer advances even in the exit frame.
        w_cnt_hold = 1'b0;
        if (w_sec_tick) begin
          w_frame_cnt_nxt = '0;
          w_cnt_inc       = 1'b1;
        end else begin
          w_frame_cnt_nxt = r_frame_cnt + CNT_W'(1);
        end

        if (w_any_dead) begin
          w_state_nxt = DYING;
          w_dying_nxt = {~bus.tank2_alive, ~bus.tank1_alive};
          if (!bus.tank1_alive && bus.tank2_alive)      w_winner_nxt = WIN_P2;
          else if (bus.tank1_alive && !bus.tank2_alive) w_winner_nxt = WIN_P1;
          else                                          w_winner_nxt = WIN_NONE;
        end else if (w_limit_tick) begin
          w_state_nxt  = DRAW;
          w_winner_nxt = WIN_NONE;
        end
`ifdef GAME_PAUSE_EN
        else if (w_pause_rise) begin
          w_state_nxt = PAUSED;
        end
`endif
      end

      DYING: begin
        if (r_death_cnt == CNT_W'(DEATH_FRAMES - 1)) begin
          w_state_nxt = (&r_dying_tank) ? DRAW : GAMEOVER;
        end else begin
          w_death_cnt_nxt = r_death_cnt + CNT_W'(1);
        end
      end

      GAMEOVER, DRAW: begin
        if (w_start_rise) begin
          w_state_nxt     = PLAY;
          w_cnt_clr       = 1'b1;
          w_frame_cnt_nxt = '0;
          w_death_cnt_nxt = '0;
          w_dying_nxt     = 2'b00;
          w_winner_nxt    = WIN_NONE;
        end
      end

`ifdef GAME_PAUSE_EN
      PAUSED: begin
        if (w_pause_rise) w_state_nxt = PLAY;
      end
`endif

      default: w_state_nxt = IDLE;
    endcase
  end

  // Sprite index tracks the next death count, saturating at the last sprite.
  always_comb begin
    w_death_div       = 32'(w_death_cnt_nxt) / DEATH_STEP;
    w_death_frame_nxt = (w_death_div > 32'd4) ? 3'd4 : 3'(w_death_div);
  end

  assign bus.state       = r_state;
  assign bus.play_en     = r_play_en;
  assign bus.hund_sec    = w_digits.hund;
  assign bus.ten_sec     = w_digits.ten;
  assign bus.one_sec     = w_digits.one;
  assign bus.dying_tank  = r_dying_tank;
  assign bus.death_frame = r_death_frame;
  assign bus.winner      = r_winner;
  assign bus.game_over   = r_game_over;
  assign bus.draw        = r_draw;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Bench for game_flow_ctrl: directed match scenarios, an integer-seconds
// reference model checked every frame, and literal spot checks.
module tb_game_flow_ctrl;

  localparam int FPS   = 3;
  localparam int DF    = 25;
  localparam int STEP  = 5;
  localparam int LIMIT = 120;

  logic frame_clk = 1'b0;
  logic Reset     = 1'b1;

  game_flow_ctrl_if bus ();

  game_flow_ctrl #(
    .FRAMES_PER_SEC (FPS),
    .DEATH_FRAMES   (DF),
    .DEATH_STEP     (STEP),
    .TIME_LIMIT     (LIMIT)
  ) dut (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .bus       (bus)
  );

  always #5 frame_clk = ~frame_clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: match phase code, elapsed seconds as an integer.
  int m_st, m_sec, m_sub, m_death, m_dying, m_win;
  bit m_start_q;

  always @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      m_st = 0; m_sec = 0; m_sub = 0; m_death = 0; m_dying = 0; m_win = 0;
      m_start_q = 0;
    end else begin
      bit rise, tick, d1, d2;
      rise = bus.start && !m_start_q;
      m_start_q = bus.start;
      d1 = !bus.tank1_alive;
      d2 = !bus.tank2_alive;
      tick = 0;
      case (m_st)
        0: begin
          m_sec = 0; m_sub = 0; m_death = 0; m_dying = 0; m_win = 0;
          if (rise) m_st = 1;
        end
        1: begin
          m_sub = m_sub + 1;
          if (m_sub == FPS) begin
            m_sub = 0;
            m_sec = (m_sec + 1) % 1000;
            tick = 1;
          end
          if (d1 || d2) begin
            m_st = 2;
            m_dying = (d2 ? 2 : 0) + (d1 ? 1 : 0);
            m_win = (d1 && !d2) ? 2 : ((d2 && !d1) ? 1 : 0);
          end else if (tick && m_sec == LIMIT) begin
            m_st = 4;
            m_win = 0;
          end
        end
        2: begin
          if (m_death == DF - 1) m_st = (m_dying == 3) ? 4 : 3;
          else m_death = m_death + 1;
        end
        default: begin
          if (rise) begin
            m_st = 1; m_sec = 0; m_sub = 0; m_death = 0; m_dying = 0; m_win = 0;
          end
        end
      endcase
    end
  end

  function automatic logic [24:0] model_vec();
    int df;
    df = m_death / STEP;
    if (df > 4) df = 4;
    return {3'(m_st), (m_st == 1),
            4'((m_sec / 100) % 10), 4'((m_sec / 10) % 10), 4'(m_sec % 10),
            2'(m_dying), 3'(df), 2'(m_win), (m_st == 3), (m_st == 4)};
  endfunction

  function automatic logic [24:0] dut_vec();
    return {bus.state, bus.play_en, bus.hund_sec, bus.ten_sec, bus.one_sec,
            bus.dying_tank, bus.death_frame, bus.winner, bus.game_over, bus.draw};
  endfunction

  // Every-frame comparison against the model.
  always @(negedge frame_clk) begin
    logic [24:0] a, e;
    a = dut_vec();
    e = model_vec();
    n_checks++;
    if (a === e) n_pass++;
    else $display("FAIL frame_cmp t=%0t actual=%h required=%h", $time, a, e);
  end

  task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h required=%h", name, act, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge frame_clk);
  endtask

  task automatic restart();
    bus.start = 1'b0; step(1);
    bus.start = 1'b1; step(1);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.tank1_alive = 1'b1;
    bus.tank2_alive = 1'b1;
`ifdef GAME_PAUSE_EN
    bus.pause = 1'b0;
`endif
    step(2);
    lit("reset_outputs", 32'(dut_vec()), 32'h0);
    Reset = 1'b0;
    step(2);
    lit("idle_state", 32'(bus.state), 32'd0);

    // Start -> PLAY after one frame.
    bus.start = 1'b1; step(1);
    lit("play_state", 32'(bus.state), 32'd1);
    lit("play_en", 32'(bus.play_en), 32'd1);
    step(3);
    lit("first_second", 32'({bus.hund_sec, bus.ten_sec, bus.one_sec}), 32'h001);
    step(33);
    lit("sec12", 32'({bus.hund_sec, bus.ten_sec, bus.one_sec}), 32'h012);

    // Tank 1 destroyed at second 12.
    bus.tank1_alive = 1'b0; step(1);
    bus.tank1_alive = 1'b1;
    lit("dying_state", 32'(bus.state), 32'd2);
    lit("dying_tank_t1", 32'(bus.dying_tank), 32'h1);
    lit("winner_p2", 32'(bus.winner), 32'h2);
    lit("death_frame0", 32'(bus.death_frame), 32'd0);
    step(5);
    lit("death_frame1", 32'(bus.death_frame), 32'd1);
    step(19);
    lit("death_frame4", 32'(bus.death_frame), 32'd4);
    lit("still_dying", 32'(bus.state), 32'd2);
    lit("digits_frozen", 32'({bus.hund_sec, bus.ten_sec, bus.one_sec}), 32'h012);
    step(1);
    lit("gameover_state", 32'(bus.state), 32'd3);
    lit("game_over_flag", 32'(bus.game_over), 32'd1);

    // Restart from GAMEOVER: everything cleared.
    restart();
    lit("restart_clear", 32'({bus.state, bus.hund_sec, bus.ten_sec, bus.one_sec,
                              bus.winner, bus.death_frame, bus.dying_tank}),
        32'({3'd1, 12'h000, 2'b00, 3'd0, 2'b00}));
    step(297);
    lit("sec099", 32'({bus.hund_sec, bus.ten_sec, bus.one_sec}), 32'h099);
    step(3);
    lit("sec100", 32'({bus.hund_sec, bus.ten_sec, bus.one_sec}), 32'h100);
    step(59);
    // Tank 2 dies on the same frame the timer reaches the limit.
    bus.tank2_alive = 1'b0; step(1);
    bus.tank2_alive = 1'b1;
    lit("limit_death_state", 32'(bus.state), 32'd2);
    lit("limit_death_winner", 32'(bus.winner), 32'h1);
    lit("limit_death_digits", 32'({bus.hund_sec, bus.ten_sec, bus.one_sec}), 32'h120);
    step(25);
    lit("gameover2", 32'(bus.state), 32'd3);

    // Full round with no deaths ends in DRAW at the limit.
    restart();
    step(359);
    lit("before_limit", 32'(bus.state), 32'd1);
    step(1);
    lit("limit_draw", 32'({bus.state, bus.draw, bus.winner, bus.game_over}),
        32'({3'd4, 1'b1, 2'b00, 1'b0}));
    lit("limit_digits", 32'({bus.hund_sec, bus.ten_sec, bus.one_sec}), 32'h120);
    step(3);
    lit("draw_hold", 32'({bus.state, bus.hund_sec, bus.ten_sec, bus.one_sec}),
        32'({3'd4, 12'h120}));

    // Both tanks destroyed together.
    restart();
    step(7);
    bus.tank1_alive = 1'b0; bus.tank2_alive = 1'b0; step(1);
    bus.tank1_alive = 1'b1; bus.tank2_alive = 1'b1;
    lit("both_dying", 32'({bus.state, bus.dying_tank, bus.winner}),
        32'({3'd2, 2'b11, 2'b00}));
    step(25);
    lit("both_draw", 32'({bus.state, bus.draw, bus.game_over}),
        32'({3'd4, 1'b1, 1'b0}));

    // Asynchronous reset in the middle of DYING.
    restart();
    step(4);
    bus.tank1_alive = 1'b0; step(1);
    bus.tank1_alive = 1'b1;
    step(3);
    lit("pre_reset_dying", 32'(bus.state), 32'd2);
    bus.start = 1'b0;
    #2 Reset = 1'b1;
    #1 lit("async_reset", 32'(dut_vec()), 32'h0);
    step(2);
    Reset = 1'b0;
    step(2);
    lit("idle_after_reset", 32'(bus.state), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/game_flow_ctrl.md
Name: game_flow_ctrl

Overview:
Top-level match sequencer for the two-player tank game, clocked once per video frame. Runs the round timer as three BCD digits and watches both tanks' alive flags. Walks the match through idle, play, death animation, game-over and draw screens. Drives the timer digits, death-sprite frame index, winner code and screen-select flags consumed by color_mapper and the tank/bullet movement logic.

Parameters:
FRAMES_PER_SEC, 60, frame_clk ticks per timer second (range 1..255)
DEATH_FRAMES, 25, frames spent in death animation before the end screen
DEATH_STEP, 5, frames per death sprite; death_frame = death_cnt / DEATH_STEP
TIME_LIMIT, 250, round length in seconds; legal range 1..999

Ports:
frame_clk  in  1  frame clock (vsync rate)
Reset  in  1  asynchronous, active-high reset
start  in  1  level from keycode decode; internally rising-edge detected
tank1_alive  in  1  0 = tank 1 destroyed
tank2_alive  in  1  0 = tank 2 destroyed
state  out  3  current game_state_t
play_en  out  1  1 only in PLAY; gates tank motion and firing
hund_sec  out  4  BCD hundreds digit of elapsed seconds
ten_sec  out  4  BCD tens digit
one_sec  out  4  BCD ones digit
dying_tank  out  2  bit0 = tank1 dying/dead, bit1 = tank2 dying/dead
death_frame  out  3  death sprite index 0..4
winner  out  2  01 = player 1, 10 = player 2, 00 = none/draw
game_over  out  1  1 in GAMEOVER
draw  out  1  1 in DRAW

Behaviour:
- Reset: state=IDLE; all digits, frame_cnt, death_cnt, dying_tank, death_frame, winner, play_en, game_over and draw = 0; start_q=0.
- start_rise = start & ~start_q; start_q is registered every frame.
- Outputs are registered and update one frame after the causing input is sampled.
- IDLE:
  - start_rise -> PLAY.
  - Clear digits, frame_cnt, death_cnt, dying_tank and winner.
- PLAY:
  - frame_cnt increments each frame.
  - When frame_cnt == FRAMES_PER_SEC-1: frame_cnt wraps to 0 and the BCD value increments.
  - ones 9->0 carries into tens; tens 9->0 carries into hundreds; 999 wraps to 000.
- Exits from PLAY, highest priority first:
  - Either alive flag low -> DYING. Latch dying_tank = {~tank2_alive, ~tank1_alive}. Winner = 10 if only tank1 dead, 01 if only tank2 dead, 00 if both dead.
  - BCD value reaches TIME_LIMIT on the increment -> DRAW, winner=00.
  - A death and the limit tick in the same frame: death wins. Digits still take the increment.
- start is ignored in PLAY, DYING and PAUSED.
- DYING:
  - Timer is frozen; death_cnt increments each frame from 0.
  - death_frame = death_cnt / DEATH_STEP, saturating at 4.
  - After death_cnt == DEATH_FRAMES-1: go to GAMEOVER if one bit of dying_tank is set, DRAW if both are set.
  - Alive flags are ignored here; dying_tank never clears before the next round.
- GAMEOVER / DRAW:
  - Hold every output, including frozen digits.
  - start_rise -> PLAY with the same clears as IDLE, plus death_cnt=0 and death_frame=0.
- Reset mid-operation returns to IDLE asynchronously regardless of state.
- play_en, game_over and draw are mutually exclusive; each is decoded from the registered state.

Optional Feature:
- Macro GAME_PAUSE_EN, defined:
  - Adds input pause (1 bit, rising-edge detected) and state PAUSED.
  - PLAY + pause_rise -> PAUSED: frame_cnt and digits are held, play_en=0.
  - PAUSED + pause_rise -> PLAY, resuming at the held frame_cnt.
  - Death detection is suspended in PAUSED.
- Macro not defined: the pause port and the PAUSED state are absent.

Decomposition:
- Package game_pkg holds:
  - game_state_t enum: IDLE=0, PLAY=1, DYING=2, GAMEOVER=3, DRAW=4, PAUSED=5.
  - Winner constants WIN_NONE, WIN_P1, WIN_P2.
  - BCD digit typedef bcd_t (logic [3:0]).
- Sub-module bcd_counter3: 3-digit BCD counter with inc, clr, hold and an async Reset. It is reused by the scoreboard.

Test Plan:
- Reset, start pulse, hold both alive 61 frames -> PLAY after 1 frame; one_sec=1 at frame 60 of PLAY; play_en=1.
- Preload via force to 009 (59 frames into the second), run 1 frame -> 010. From 099 -> 100. From 999 with TIME_LIMIT=999 override: reaching 999 -> DRAW.
- tank1_alive=0 at second 12 -> DYING, dying_tank=01, winner=10; death_frame steps 0,1,2,3,4 every 5 frames; digits stay 012; GAMEOVER after 25 frames, game_over=1.
- Both alive flags drop in the same frame -> dying_tank=11, winner=00; after 25 frames -> DRAW, draw=1, game_over=0.
- Timer reaches 250 in the same frame tank2 dies -> DYING with winner=01, not DRAW; digits read 250.
- In GAMEOVER, start pulse -> PLAY, digits 000, winner 00, death_frame 0. Assert Reset mid-DYING -> IDLE immediately with all outputs 0.
